// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// op encoding, FSM states, ALU control codes and the iteration bound.
package muldiv_pkg;

   // op[0] selects divide, op[1] selects signed
   localparam int OP_DIV = 0;
   localparam int OP_SGN = 1;

   typedef enum logic [2:0] {
      IDLE,
      PREP_A,
      PREP_B,
      ITER,
      FIX_LO,
      FIX_HI,
      FIX_HC,
      DONE
   } state_t;

   localparam logic [3:0] ALUC_ADD = 4'b0000;
   localparam logic [3:0] ALUC_SUB = 4'b0100;  // X - Y
   localparam logic [3:0] ALUC_XOR = 4'b0010;

   localparam logic [4:0] ITER_LAST = 5'd31;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide. Purely
// combinational: drives the shared ALU operands and folds the ALU result
// back into the next {hi,lo}. Carry/borrow is rebuilt from operand and
// result MSBs because the shared ALU exposes no carry output.
module muldiv_step
   import muldiv_pkg::*;
(
   input  logic        is_div,
   input  logic [31:0] hi,
   input  logic [31:0] lo,
   input  logic [31:0] m,
   input  logic [31:0] alu_r,
   output logic [31:0] x,
   output logic [31:0] y,
   output logic [3:0]  aluc,
   output logic [31:0] hi_nxt,
   output logic [31:0] lo_nxt
);

   logic [31:0] shifted;
   logic        top;
   logic        cb;

   // Operand select, carry/borrow recovery and next-state fold for one step
   always_comb begin
      shifted = {hi[30:0], lo[31]};
      top     = hi[31];
      x       = hi;
      y       = '0;
      aluc    = ALUC_ADD;
      cb      = 1'b0;
      hi_nxt  = hi;
      lo_nxt  = lo;
      if (is_div) begin
         // Partial remainder is 33 bits wide: 'top' is the bit shifted out
         x    = shifted;
         y    = m;
         aluc = ALUC_SUB;
         cb   = (~x[31] & y[31]) | (~(x[31] ^ y[31]) & alu_r[31]);
         if (top | ~cb) begin
            hi_nxt = alu_r;
            lo_nxt = {lo[30:0], 1'b1};
         end else begin
            hi_nxt = shifted;
            lo_nxt = {lo[30:0], 1'b0};
         end
      end else begin
         x    = hi;
         y    = lo[0] ? m : 32'd0;
         aluc = ALUC_ADD;
         cb   = (x[31] & y[31]) | ((x[31] | y[31]) & ~alu_r[31]);
         {hi_nxt, lo_nxt} = {cb, alu_r, lo[31:1]};
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative 32x32 multiply/divide sequencer borrowing the core's ALU.
// While busy, the datapath operand mux hands alu_x/alu_y/alu_aluc to the
// ALU and alu_r comes straight back in the same cycle. Results in hi/lo.
// Build option: define MULDIV_SIGNED_EN to add signed operation (operand
// magnitude prep and result sign fix-up states); without it op[1] is
// ignored and every operation is unsigned.
module muldiv_seq
   import muldiv_pkg::*;
(
   input  logic        Clk,
   input  logic        Clrn,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cancel,
   input  logic [31:0] alu_r,
   output logic [31:0] alu_x,
   output logic [31:0] alu_y,
   output logic [3:0]  alu_aluc,
   output logic        busy,
   output logic        done,
   output logic        div0,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   state_t      state, state_nxt;
   logic [4:0]  count;
   logic [31:0] opa, opb;
   logic        is_div, div0_f;
   logic        accept, div_zero;
   logic [31:0] step_x, step_y, step_m, step_hi, step_lo;
   logic [3:0]  step_aluc;

`ifdef MULDIV_SIGNED_EN
   logic sgn_in, sgn, neg_a, neg_b, neg_q, lo_zero;
   assign sgn_in = op[OP_SGN];
   // Quotient and product share the same sign rule; remainder follows a
   assign neg_q  = neg_a ^ neg_b;
`else
   logic unused_sgn;
   assign unused_sgn = op[OP_SGN];
`endif

   // cancel beats start when both arrive in IDLE/DONE
   assign accept   = (state == IDLE || state == DONE) && start && !cancel;
   assign div_zero = op[OP_DIV] && (b == 32'd0);
   assign step_m   = is_div ? opb : opa;

   muldiv_step u_step (
      .is_div (is_div),
      .hi     (hi),
      .lo     (lo),
      .m      (step_m),
      .alu_r  (alu_r),
      .x      (step_x),
      .y      (step_y),
      .aluc   (step_aluc),
      .hi_nxt (step_hi),
      .lo_nxt (step_lo)
   );

   // State register
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state, ALU drive and status outputs
   always_comb begin
      state_nxt = state;
      alu_x     = '0;
      alu_y     = '0;
      alu_aluc  = ALUC_ADD;
      busy      = (state != IDLE) && (state != DONE);
      done      = (state == DONE);
      div0      = (state == DONE) && div0_f;
      case (state)
         IDLE, DONE: begin
            state_nxt = IDLE;
            if (accept) begin
               if (div_zero)    state_nxt = DONE;
`ifdef MULDIV_SIGNED_EN
               else if (sgn_in) state_nxt = PREP_A;
`endif
               else             state_nxt = ITER;
            end
         end
         ITER: begin
            alu_x    = step_x;
            alu_y    = step_y;
            alu_aluc = step_aluc;
            if (count == ITER_LAST) begin
`ifdef MULDIV_SIGNED_EN
               state_nxt = sgn ? FIX_LO : DONE;
`else
               state_nxt = DONE;
`endif
            end
         end
`ifdef MULDIV_SIGNED_EN
         PREP_A: begin
            alu_y     = opa;
            alu_aluc  = ALUC_SUB;
            state_nxt = PREP_B;
         end
         PREP_B: begin
            alu_y     = opb;
            alu_aluc  = ALUC_SUB;
            state_nxt = ITER;
         end
         FIX_LO: begin
            alu_y     = lo;
            alu_aluc  = ALUC_SUB;
            state_nxt = FIX_HI;
         end
         FIX_HI: begin
            if (is_div) begin
               alu_y     = hi;
               alu_aluc  = ALUC_SUB;
               state_nxt = DONE;
            end else begin
               alu_x     = hi;
               alu_y     = 32'hFFFF_FFFF;
               alu_aluc  = ALUC_XOR;
               state_nxt = FIX_HC;
            end
         end
         FIX_HC: begin
            // Carry of the two's-complement negate of lo into the upper word
            alu_x     = hi;
            alu_y     = {31'd0, lo_zero};
            alu_aluc  = ALUC_ADD;
            state_nxt = DONE;
         end
`endif
         default: state_nxt = IDLE;
      endcase
      if (busy && cancel) state_nxt = IDLE;
   end

   // Operand latch, iteration and sign fix-up; a cancelled cycle writes nothing
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         count   <= '0;
         opa     <= '0;
         opb     <= '0;
         is_div  <= 1'b0;
         div0_f  <= 1'b0;
         hi      <= '0;
         lo      <= '0;
`ifdef MULDIV_SIGNED_EN
         sgn     <= 1'b0;
         neg_a   <= 1'b0;
         neg_b   <= 1'b0;
         lo_zero <= 1'b0;
`endif
      end else if (accept) begin
         is_div <= op[OP_DIV];
         opa    <= a;
         opb    <= b;
         count  <= '0;
         div0_f <= div_zero;
`ifdef MULDIV_SIGNED_EN
         sgn    <= sgn_in;
         neg_a  <= sgn_in & a[31];
         neg_b  <= sgn_in & b[31];
`endif
         if (div_zero) begin
            hi <= a;
            lo <= 32'hFFFF_FFFF;
         end else begin
            hi <= '0;
            lo <= op[OP_DIV] ? a : b;
         end
      end else if (!cancel) begin
         case (state)
            ITER: begin
               hi    <= step_hi;
               lo    <= step_lo;
               count <= count + 5'd1;
            end
`ifdef MULDIV_SIGNED_EN
            PREP_A: if (neg_a) opa <= alu_r;
            PREP_B: begin
               // Reload lo with the magnitude now that both operands are known
               if (neg_b) opb <= alu_r;
               hi <= '0;
               if (is_div)     lo <= opa;
               else if (neg_b) lo <= alu_r;
               else            lo <= opb;
            end
            FIX_LO: begin
               lo_zero <= (lo == 32'd0);
               if (neg_q) lo <= alu_r;
            end
            FIX_HI: if (is_div ? neg_a : neg_q) hi <= alu_r;
            FIX_HC: if (neg_q) hi <= alu_r;
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a behavioural model of the shared ALU.
module tb_muldiv_seq;

   logic        Clk, Clrn, start, cancel;
   logic [1:0]  op;
   logic [31:0] a, b, alu_r, alu_x, alu_y, hi, lo;
   logic [3:0]  alu_aluc;
   logic        busy, done, div0;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

`ifdef MULDIV_SIGNED_EN
   localparam int LAT_SM = 38;
   localparam int LAT_SD = 37;
`else
   localparam int LAT_SM = 33;
   localparam int LAT_SD = 33;
`endif

   muldiv_seq dut (
      .Clk      (Clk),
      .Clrn     (Clrn),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .cancel   (cancel),
      .alu_r    (alu_r),
      .alu_x    (alu_x),
      .alu_y    (alu_y),
      .alu_aluc (alu_aluc),
      .busy     (busy),
      .done     (done),
      .div0     (div0),
      .hi       (hi),
      .lo       (lo)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   // Shared ALU
   always_comb begin
      case (alu_aluc)
         4'b0000: alu_r = alu_x + alu_y;
         4'b0100: alu_r = alu_x - alu_y;
         4'b0010: alu_r = alu_x ^ alu_y;
         default: alu_r = '0;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                           output int t0);
      @(negedge Clk);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge Clk); #1;
      start = 1'b0;
      t0 = cyc;
   endtask

   task automatic wait_done(input int t0);
      while (!done && (cyc - t0) < 60) begin
         @(posedge Clk); #1;
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input int lat, input logic [31:0] ehi,
                         input logic [31:0] elo, input logic ediv0);
      int t0;
      start_op(o, x, y, t0);
      wait_done(t0);
      chk({tag, "_lat"},  32'(cyc - t0 + 1), 32'(lat));
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
      chk({tag, "_div0"}, {31'd0, div0}, {31'd0, ediv0});
      chk({tag, "_hi"},   hi, ehi);
      chk({tag, "_lo"},   lo, elo);
   endtask

   initial begin
      int t0;
      int seen;
      Clrn = 1'b0; start = 1'b0; cancel = 1'b0; op = 2'b00; a = '0; b = '0;
      repeat (3) @(posedge Clk);
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_div0", {31'd0, div0}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_alux", alu_x, 32'd0);
      chk("rst_aluy", alu_y, 32'd0);
      chk("rst_aluc", {28'd0, alu_aluc}, 32'd0);
      @(negedge Clk);
      Clrn = 1'b1;

      run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      // issued from the DONE cycle above: back-to-back acceptance
`ifdef MULDIV_SIGNED_EN
      run_op("mult_neg", 2'b10, 32'hFFFF_FFFD, 32'd7, LAT_SM, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
      run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, LAT_SD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, LAT_SD, 32'h0, 32'h8000_0000, 1'b0);
      run_op("mult_zero", 2'b10, 32'hFFFF_FFFF, 32'd0, LAT_SM, 32'h0, 32'h0, 1'b0);
      run_op("mult_m1", 2'b10, 32'h0001_0000, 32'hFFFF_FFFF, LAT_SM, 32'hFFFF_FFFF, 32'hFFFF_0000, 1'b0);
`else
      run_op("mult_neg", 2'b10, 32'hFFFF_FFFD, 32'd7, LAT_SM, 32'h0000_0006, 32'hFFFF_FFEB, 1'b0);
      run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, LAT_SD, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0);
      run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, LAT_SD, 32'h8000_0000, 32'h0, 1'b0);
      run_op("mult_zero", 2'b10, 32'hFFFF_FFFF, 32'd0, LAT_SM, 32'h0, 32'h0, 1'b0);
      run_op("mult_m1", 2'b10, 32'h0001_0000, 32'hFFFF_FFFF, LAT_SM, 32'h0000_FFFF, 32'hFFFF_0000, 1'b0);
`endif
      run_op("divu_zero", 2'b01, 32'd100, 32'd0, 1, 32'd100, 32'hFFFF_FFFF, 1'b1);
      @(posedge Clk); #1;
      chk("pulse_done", {31'd0, done}, 32'd0);
      chk("pulse_div0", {31'd0, div0}, 32'd0);

      // start while busy must not disturb the running divide
      start_op(2'b01, 32'd1000, 32'd7, t0);
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5;
      @(posedge Clk); #1;
      start = 1'b0;
      wait_done(t0);
      chk("ign_lat", 32'(cyc - t0 + 1), 32'd33);
      chk("ign_lo", lo, 32'd142);
      chk("ign_hi", hi, 32'd6);

      // cancel mid-iteration
      start_op(2'b01, 32'd1000, 32'd7, t0);
      repeat (9) begin
         @(posedge Clk); #1;
      end
      cancel = 1'b1;
      @(posedge Clk); #1;
      cancel = 1'b0;
      chk("cancel_busy", {31'd0, busy}, 32'd0);
      seen = 0;
      repeat (40) begin
         @(posedge Clk); #1;
         if (done) seen++;
      end
      chk("cancel_nodone", 32'(seen), 32'd0);

      run_op("restart", 2'b01, 32'd1000, 32'd7, 33, 32'd6, 32'd142, 1'b0);

      // start together with cancel in IDLE/DONE is dropped
      @(negedge Clk);
      start = 1'b1; cancel = 1'b1; op = 2'b00; a = 32'd3; b = 32'd3;
      @(posedge Clk); #1;
      start = 1'b0; cancel = 1'b0;
      chk("stcan_busy", {31'd0, busy}, 32'd0);
      chk("stcan_done", {31'd0, done}, 32'd0);

      // asynchronous reset in the middle of an operation
      start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, t0);
      repeat (10) begin
         @(posedge Clk); #1;
      end
      chk("mid_busy", {31'd0, busy}, 32'd1);
      #2 Clrn = 1'b0;
      #1;
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_hi", hi, 32'd0);
      chk("arst_lo", lo, 32'd0);
      chk("arst_alux", alu_x, 32'd0);
      chk("arst_aluy", alu_y, 32'd0);
      @(negedge Clk);
      Clrn = 1'b1;
      @(posedge Clk); #1;
      chk("arst_idle", {31'd0, busy}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative 32×32 multiply/divide sequencer that borrows the shared 32-bit ALU for all arithmetic. It runs shift-add multiply or restoring divide over 32 iterations, issuing one ALU add/sub per cycle and deriving carry/borrow from operand and result MSBs. It sits beside the core datapath; while `busy`=1 the datapath operand mux routes `alu_x`/`alu_y`/`alu_aluc` to the ALU. Results land in HI/LO.

## Interface
- No parameters; width is fixed at 32.
- `Clk` in 1: single clock, rising edge.
- `Clrn` in 1: reset, asynchronous, active-low.
- `start` in 1: request; sampled only in IDLE or DONE.
- `op` in 2: bit 0 selects divide (0 = multiply); bit 1 selects signed.
- `a`, `b` in 32: multiplicand/multiplier, or dividend/divisor.
- `cancel` in 1: synchronous abort (exception/interrupt flush).
- `alu_r` in 32: ALU result R.
- `alu_x`, `alu_y` out 32: ALU operands X, Y.
- `alu_aluc` out 4: ALU control Aluc.
- `busy` out 1: ALU owned by the sequencer.
- `done` out 1: one-cycle result-valid pulse.
- `div0` out 1: divide-by-zero, valid with `done`.
- `hi`, `lo` out 32: product {hi,lo}, or remainder hi / quotient lo.

## Operation
- States: IDLE, PREP_A, PREP_B, ITER, FIX_LO, FIX_HI, FIX_HC, DONE. `busy` = state not in {IDLE, DONE}.
- ALU codes:
  - ADD = 4'b0000
  - SUB = 4'b0100, computes X−Y
  - XOR = 4'b0010
- Carry/borrow:
  - Add carry = X31&Y31 | (X31|Y31)&~R31.
  - Sub borrow = ~X31&Y31 | ~(X31^Y31)&R31.
- Start handling in IDLE/DONE:
  - Divide with b=0 → DONE with `div0`=1, hi=a, lo=32'hFFFF_FFFF.
  - Otherwise signed → PREP_A; unsigned → ITER with count=0.
  - Start also latches the operands and the sign flags.
- PREP_A/PREP_B: if the operand is negative, ALU SUB 0−x replaces it with its magnitude; otherwise it is unchanged.
- ITER, multiply:
  - Init hi=0, lo=multiplier.
  - Each cycle: ALU ADD hi + (lo[0] ? mcand : 0).
  - Then {hi,lo} ← {carry, R, lo[31:1]}.
- ITER, divide (restoring):
  - Init hi=0, lo=dividend; t=hi[31].
  - Each cycle: ALU SUB {hi[30:0],lo[31]} − divisor.
  - If t | ~borrow: hi ← R, lo ← {lo[30:0],1}.
  - Else: hi ← shifted value, lo ← {lo[30:0],0}.
- ITER exit after count=31: signed → FIX_LO; unsigned → DONE.
- FIX stages:
  - FIX_LO: negate quotient/product-lo via SUB 0−lo when the result sign is negative. Multiply records lo_was_zero.
  - FIX_HI, multiply: XOR hi with 32'hFFFF_FFFF if negating.
  - FIX_HI, divide: SUB 0−hi if the dividend was negative.
  - FIX_HC, multiply only: ADD hi + lo_was_zero if negating. Divide goes from FIX_HI straight to DONE.
- FIX states are always traversed for signed ops; registers are written only when negation applies.
- DIV 32'h8000_0000 / −1 yields lo=32'h8000_0000, hi=0, no flag.
- `cancel` in any busy state → IDLE next cycle, no `done`. hi/lo keep their partial values.
- `start` while busy is ignored. `start` and `cancel` together in IDLE/DONE: `cancel` wins, `start` dropped.

## Timing
- Reset: state=IDLE; all outputs 0, including hi, lo and the ALU drive.
- Latency from the `start` edge to the `done` cycle:
  - Unsigned: 33.
  - Signed multiply: 38.
  - Signed divide: 37.
  - Divide by zero: 1.
- `done`/`div0` high exactly one cycle (DONE state). hi/lo are stable from DONE until the next accepted start.
- Back-to-back: `start` in DONE is accepted; the next op begins the following cycle.
- `alu_r` is consumed combinationally in the same cycle the operands are driven; no ALU pipeline stage.
- `Clrn` asserted mid-operation: immediate IDLE, outputs 0.

## Configuration
- `MULDIV_SIGNED_EN` defined: full behaviour above.
- `MULDIV_SIGNED_EN` undefined: `op[1]` ignored; PREP_* and FIX_* states not built; all ops unsigned with 33-cycle latency.

## Structure
- Package `muldiv_pkg`:
  - op encoding
  - state enum
  - ALU code constants ALUC_ADD / ALUC_SUB / ALUC_XOR
  - ITER_LAST = 31
- Sub-module `muldiv_step`: combinational. Given mode, hi, lo, divisor/mcand and `alu_r`, it produces the ALU operands, carry/borrow, and next hi/lo for one ITER cycle.

## Test plan
- MULTU FFFF_FFFF × FFFF_FFFF → done at +33, hi=FFFF_FFFE, lo=0000_0001.
- MULT FFFF_FFFD × 7 → done at +38, hi=FFFF_FFFF, lo=FFFF_FFEB.
- DIV FFFF_FFF9 / 2 → done at +37, lo=FFFF_FFFD, hi=FFFF_FFFF.
- DIV 8000_0000 / FFFF_FFFF → lo=8000_0000, hi=0, div0=0.
- DIVU 100 / 0 → done+div0 at +1, hi=100, lo=FFFF_FFFF.
- DIVU 1000/7, then:
  - `start` pulsed at +3 is ignored.
  - `cancel` at +10 → busy=0 at +11, no done.
  - Restart → lo=142, hi=6.
  - `Clrn` low mid-op → outputs 0 at once.
